// File: rtl/vx_mp_ram.sv
`default_nettype none
// ============================================================================
// Module   : vx_mp_ram
// Brief    : Multi-read-port RAM with lane write enables and a post-reset init sweep
// Revision : 1.0
// ============================================================================
module vx_mp_ram #(
    parameter int              DATAW      = 32,
    parameter int              SIZE       = 64,
    parameter int              WRENW      = 4,
    parameter int              NUM_RPORTS = 2,
    parameter int              OUT_REG    = 0,
    parameter int              RDW_MODE   = 0,
    parameter logic [DATAW-1:0] INIT_VALUE = '0,
    parameter int              ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          init_done,
    input  logic                          write,
    input  logic [WRENW-1:0]              wren,
    input  logic [ADDRW-1:0]              waddr,
    input  logic [DATAW-1:0]              wdata,
    input  logic [NUM_RPORTS-1:0]         read,
    input  logic [NUM_RPORTS*ADDRW-1:0]   raddr,
    output logic [NUM_RPORTS*DATAW-1:0]   rdata,
    output logic [NUM_RPORTS-1:0]         rvalid
);

    localparam int               c_LW     = DATAW / WRENW;
    localparam logic [ADDRW:0]   c_SIZE_X = (ADDRW+1)'(SIZE);
    localparam logic [ADDRW-1:0] c_LAST   = ADDRW'(SIZE - 1);

    if ((DATAW % WRENW) != 0) begin : g_chk_lanes
        $error("vx_mp_ram: DATAW must be a multiple of WRENW");
    end
    if (SIZE < 2) begin : g_chk_size
        $error("vx_mp_ram: SIZE must be at least 2");
    end
    if (NUM_RPORTS < 1) begin : g_chk_ports
        $error("vx_mp_ram: NUM_RPORTS must be at least 1");
    end

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The last sweep write and the move to READY share one edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            if (cnt_q == c_LAST) begin
                state_d = S_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign init_done = (state_q == S_READY);

    logic [DATAW-1:0] mem_q [SIZE];
    logic             w_waddr_ok;
    logic             w_wr_en;

    assign w_waddr_ok = ({1'b0, waddr} < c_SIZE_X);
    assign w_wr_en    = init_done & write & w_waddr_ok;

    // Memory has no reset: its contents are defined only by the sweep.
    always_ff @(posedge clk) begin
        if (!init_done) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (w_wr_en) begin
            for (int i = 0; i < WRENW; i++) begin
                if (wren[i]) begin
                    mem_q[waddr][i*c_LW +: c_LW] <= wdata[i*c_LW +: c_LW];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        logic [ADDRW-1:0] w_addr;
        logic             w_addr_ok;
        logic             w_hit;
        logic [DATAW-1:0] w_rmem;
        logic [DATAW-1:0] w_rval;

        assign w_addr    = raddr[p*ADDRW +: ADDRW];
        assign w_addr_ok = ({1'b0, w_addr} < c_SIZE_X);
        assign w_rmem    = w_addr_ok ? mem_q[w_addr] : '0;
        assign w_hit     = (RDW_MODE != 0) && w_wr_en && (w_addr == waddr);

        // Forwarding merges only the lanes actually being written.
        always_comb begin
            w_rval = w_rmem;
            for (int i = 0; i < WRENW; i++) begin
                if (w_hit && wren[i]) begin
                    w_rval[i*c_LW +: c_LW] = wdata[i*c_LW +: c_LW];
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATAW-1:0] rdata_q;
            logic             rvalid_q;
            logic             w_take;

            assign w_take = read[p] & init_done;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= w_take;
                    if (w_take) begin
                        rdata_q <= w_rval;
                    end
                end
            end

            assign rdata[p*DATAW +: DATAW] = rdata_q;
            assign rvalid[p]               = rvalid_q;
        end else begin : g_ocomb
            assign rdata[p*DATAW +: DATAW] = w_rval;
            assign rvalid[p]               = read[p] & init_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_mp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_mp_ram
// Brief    : Directed bench for vx_mp_ram across four parameter sets
// Revision : 1.0
// ============================================================================
module tb_vx_mp_ram;

    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [3:0]  wren;
    logic [AW-1:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  read;
    logic [2*AW-1:0] raddr;

    logic        done_a, done_b, done_c, done_d;
    logic [63:0] rdata_a, rdata_b, rdata_c, rdata_d;
    logic [1:0]  rvalid_a, rvalid_b, rvalid_c, rvalid_d;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // a: forwarding, combinational; b: old-data, combinational
    // c: old-data, registered; d: 48 words, combinational
    vx_mp_ram #(.SIZE(64), .INIT_VALUE(32'hA5A5A5A5), .OUT_REG(0), .RDW_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .init_done(done_a), .write(write), .wren(wren),
        .waddr(waddr), .wdata(wdata), .read(read), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a));
    vx_mp_ram #(.SIZE(64), .INIT_VALUE(32'hA5A5A5A5), .OUT_REG(0), .RDW_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .init_done(done_b), .write(write), .wren(wren),
        .waddr(waddr), .wdata(wdata), .read(read), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b));
    vx_mp_ram #(.SIZE(64), .INIT_VALUE(32'hA5A5A5A5), .OUT_REG(1), .RDW_MODE(0)) dut_c (
        .clk(clk), .reset(reset), .init_done(done_c), .write(write), .wren(wren),
        .waddr(waddr), .wdata(wdata), .read(read), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c));
    vx_mp_ram #(.SIZE(48), .INIT_VALUE(32'hA5A5A5A5), .OUT_REG(0), .RDW_MODE(0)) dut_d (
        .clk(clk), .reset(reset), .init_done(done_d), .write(write), .wren(wren),
        .waddr(waddr), .wdata(wdata), .read(read), .raddr(raddr),
        .rdata(rdata_d), .rvalid(rvalid_d));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_raddr(input int a1, input int a0);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        wren  = 4'h0;
        waddr = '0;
        wdata = '0;
        read  = 2'b11;
        raddr = '0;
        repeat (2) @(negedge clk);

        chk("reset_done", {63'd0, done_a}, 64'd0);
        chk("reset_rvalid_comb", {62'd0, rvalid_a}, 64'd0);
        chk("reset_rvalid_reg", {62'd0, rvalid_c}, 64'd0);
        chk("reset_rdata_reg", rdata_c, 64'd0);

        // Init sweep; user writes to an already-swept address must be ignored.
        reset = 1'b0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin
                write = 1'b1; waddr = AW'(3); wdata = 32'h0; wren = 4'hF;
            end
            if (cyc == 60) write = 1'b0;
            if (cyc == 20) begin
                chk("init_rvalid_comb", {62'd0, rvalid_a}, 64'd0);
                chk("init_rvalid_reg", {62'd0, rvalid_c}, 64'd0);
            end
            if (cyc == 47) chk("done48_early", {63'd0, done_d}, 64'd0);
            if (cyc == 48) chk("done48_rise", {63'd0, done_d}, 64'd1);
            if (cyc == 50) chk("rvalid48_ready", {62'd0, rvalid_d}, 64'd3);
            if (cyc == 63) chk("done64_early", {63'd0, done_a}, 64'd0);
            if (cyc == 64) begin
                chk("done64_rise_a", {63'd0, done_a}, 64'd1);
                chk("done64_rise_b", {63'd0, done_b}, 64'd1);
                chk("done64_rise_c", {63'd0, done_c}, 64'd1);
            end
        end
        wren = 4'h0;

        for (int a = 0; a < 64; a++) begin
            set_raddr(a, a);
            #1;
            chk($sformatf("sweep_%0d", a), rdata_a, {32'hA5A5A5A5, 32'hA5A5A5A5});
        end

        // Partial-lane write, observed during the write edge on both RDW modes.
        @(negedge clk);
        write = 1'b1; waddr = AW'(3); wdata = 32'h11223344; wren = 4'b0101;
        set_raddr(3, 3);
        #1;
        chk("rdw_new_lanes", {32'd0, rdata_a[63:32]}, 64'hA522A544);
        chk("rdw_old_lanes", {32'd0, rdata_b[63:32]}, 64'hA5A5A5A5);
        chk("rvalid_comb_b", {62'd0, rvalid_b}, 64'd3);
        @(negedge clk);
        write = 1'b0;
        #1;
        chk("reg_rdw_old", rdata_c, {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("reg_rvalid", {62'd0, rvalid_c}, 64'd3);
        chk("lane_merge", {32'd0, rdata_b[31:0]}, 64'hA522A544);

        // Full-word read-during-write on port 1.
        @(negedge clk);
        write = 1'b1; waddr = AW'(7); wdata = 32'hDEADBEEF; wren = 4'hF;
        set_raddr(7, 3);
        #1;
        chk("rdw_fwd_full", {32'd0, rdata_a[63:32]}, 64'hDEADBEEF);
        chk("rdw_old_full", {32'd0, rdata_b[63:32]}, 64'hA5A5A5A5);
        @(negedge clk);
        chk("reg_rdw_old_full", {32'd0, rdata_c[63:32]}, 64'hA5A5A5A5);

        waddr = AW'(5); wdata = 32'h55550005;
        @(negedge clk);
        waddr = AW'(9); wdata = 32'h99990009;
        @(negedge clk);
        waddr = AW'(5); wdata = 32'h0; wren = 4'h0;
        @(negedge clk);
        write = 1'b0; wdata = 32'hFFFFFFFF; wren = 4'hF;
        @(negedge clk);

        // Two registered reads in one cycle, then an idle cycle.
        set_raddr(9, 5);
        read = 2'b11;
        #1;
        chk("comb_two_ports", rdata_a, {32'h99990009, 32'h55550005});
        chk("comb_rvalid_on", {62'd0, rvalid_a}, 64'd3);
        @(negedge clk);
        chk("reg_two_valid", {62'd0, rvalid_c}, 64'd3);
        chk("reg_two_data", rdata_c, {32'h99990009, 32'h55550005});
        read = 2'b00;
        set_raddr(0, 0);
        #1;
        chk("comb_rvalid_off", {62'd0, rvalid_a}, 64'd0);
        @(negedge clk);
        chk("reg_idle_valid", {62'd0, rvalid_c}, 64'd0);
        chk("reg_idle_hold", rdata_c, {32'h99990009, 32'h55550005});

        set_raddr(5, 5);
        read = 2'b11;
        #1;
        chk("same_addr_ports", rdata_a, {32'h55550005, 32'h55550005});

        // Out-of-range handling on the 48-word instance.
        @(negedge clk);
        write = 1'b1; waddr = AW'(50); wdata = 32'h12345678; wren = 4'hF;
        @(negedge clk);
        write = 1'b0;
        set_raddr(47, 50);
        #1;
        chk("oor_read_zero", rdata_d, {32'hA5A5A5A5, 32'h0});
        chk("inrange_64", {32'd0, rdata_a[31:0]}, 64'h12345678);

        // Reset mid-sweep at counter 30, then a full restart.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midsweep_done", {63'd0, done_a}, 64'd0);
        chk("midsweep_rdata_reg", rdata_c, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        read = 2'b11;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            if (cyc == 44) begin
                write = 1'b1; waddr = AW'(40); wdata = 32'h0; wren = 4'hF;
            end
            if (cyc == 58) write = 1'b0;
            if (cyc == 30) begin
                chk("restart_rvalid_comb", {62'd0, rvalid_a}, 64'd0);
                chk("restart_rvalid_reg", {62'd0, rvalid_c}, 64'd0);
            end
            if (cyc == 63) chk("restart_done_early", {63'd0, done_a}, 64'd0);
            if (cyc == 64) chk("restart_done_rise", {63'd0, done_a}, 64'd1);
        end
        set_raddr(50, 40);
        #1;
        chk("restart_contents", rdata_a, {32'hA5A5A5A5, 32'hA5A5A5A5});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
